// File: rtl/div_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : div_unit_if
//  Description : Request/response bundle between the Execute stage and the
//                iterative divide/remainder unit.
//                master modport = pipeline side, slave modport = div_unit.
//  Signals     : start_i, kill_i, funct3_i[2:0], word_i, dividend_i,
//                divisor_i (requests); busy_o, done_o, result_o (responses)
//  Revision    : 1.0  initial release
// ============================================================================
interface div_unit_if #(
  parameter int XLEN = 64
);
  logic            start_i;
  logic            kill_i;
  logic [2:0]      funct3_i;
  logic            word_i;
  logic [XLEN-1:0] dividend_i;
  logic [XLEN-1:0] divisor_i;
  logic            busy_o;
  logic            done_o;
  logic [XLEN-1:0] result_o;

  modport master (
    output start_i, kill_i, funct3_i, word_i, dividend_i, divisor_i,
    input  busy_o, done_o, result_o
  );

  modport slave (
    input  start_i, kill_i, funct3_i, word_i, dividend_i, divisor_i,
    output busy_o, done_o, result_o
  );
endinterface
`default_nettype wire

// File: rtl/div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : div_unit
//  Description : Iterative RV64M DIV/DIVU/REM/REMU (+W variants) unit.
//                Restoring shift-subtract, one quotient bit per cycle.
//                64-bit op: done_o 66 cycles after the accepted start,
//                W op: 34 cycles. busy_o stalls the pipeline meanwhile.
//  Ports       : clk_i        core clock
//                rst_ni       synchronous active-low reset
//                bus (slave)  start_i/kill_i/funct3_i/word_i/dividend_i/
//                             divisor_i in; busy_o/done_o/result_o out
//  Options     : DIV_FASTPATH_EN - when defined, divide-by-zero and signed
//                overflow finish one cycle after accept without iterating.
//  Revision    : 1.0  initial release
// ============================================================================
module div_unit #(
  parameter int XLEN = 64
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  div_unit_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t          r_state;
  logic [6:0]      r_cnt;
  logic [XLEN-1:0] r_q;          // dividend bits shift out the top, quotient bits in at the bottom
  logic [XLEN-1:0] r_rem;        // partial remainder, always < divisor between steps
  logic [XLEN-1:0] r_dvs;        // divisor magnitude
  logic            r_word;
  logic            r_is_rem;
  logic            r_neg_q;
  logic            r_neg_r;
  logic            r_special;
  logic [XLEN-1:0] r_spec_res;
  logic            r_busy;
  logic            r_done;
  logic [XLEN-1:0] r_result;

  assign bus.busy_o   = r_busy;
  assign bus.done_o   = r_done;
  assign bus.result_o = r_result;

  // --------------------------------------------------------------------------
  // Operand preparation (evaluated on the request inputs, used at accept)
  // --------------------------------------------------------------------------
  logic            w_signed;
  logic            w_rem;
  logic [XLEN-1:0] w_a_ext;
  logic [XLEN-1:0] w_b_ext;
  logic            w_sa;
  logic            w_sb;
  logic [XLEN-1:0] w_a_abs;
  logic [XLEN-1:0] w_b_abs;
  logic [XLEN-1:0] w_q_init;
  logic [XLEN-1:0] w_min;
  logic [XLEN-1:0] w_a_res;
  logic            w_dz;
  logic            w_ovf;
  logic [XLEN-1:0] w_spec_res;

  // Only 100 (DIV) and 110 (REM) are signed; 0xx codes fall through as DIVU.
  assign w_signed = bus.funct3_i[2] & ~bus.funct3_i[0];
  assign w_rem    = bus.funct3_i[2] &  bus.funct3_i[1];

  always_comb begin
    w_a_ext = bus.dividend_i;
    w_b_ext = bus.divisor_i;
    if (bus.word_i) begin
      if (w_signed) begin
        w_a_ext = {{(XLEN-32){bus.dividend_i[31]}}, bus.dividend_i[31:0]};
        w_b_ext = {{(XLEN-32){bus.divisor_i[31]}},  bus.divisor_i[31:0]};
      end else begin
        w_a_ext = {{(XLEN-32){1'b0}}, bus.dividend_i[31:0]};
        w_b_ext = {{(XLEN-32){1'b0}}, bus.divisor_i[31:0]};
      end
    end
  end

  assign w_sa    = w_signed & w_a_ext[XLEN-1];
  assign w_sb    = w_signed & w_b_ext[XLEN-1];
  assign w_a_abs = w_sa ? (~w_a_ext + 1'b1) : w_a_ext;
  assign w_b_abs = w_sb ? (~w_b_ext + 1'b1) : w_b_ext;

  // W operands are pre-aligned to the top of r_q so the same shift path
  // consumes exactly 32 dividend bits; the quotient lands in r_q[31:0].
  assign w_q_init = bus.word_i ? {w_a_abs[31:0], {(XLEN-32){1'b0}}} : w_a_abs;

  // Most-negative value at the operative width (already sign-extended for W).
  assign w_min = bus.word_i ? {{(XLEN-31){1'b1}}, {31{1'b0}}}
                            : {1'b1, {(XLEN-1){1'b0}}};

  assign w_dz  = (w_b_ext == '0);
  assign w_ovf = w_signed & (w_a_ext == w_min) & (&w_b_ext);

  // Dividend as it appears in special results: W always sign-extends bit 31.
  assign w_a_res = bus.word_i ? {{(XLEN-32){bus.dividend_i[31]}}, bus.dividend_i[31:0]}
                              : bus.dividend_i;

  always_comb begin
    w_spec_res = '0;
    if (w_dz) begin
      w_spec_res = w_rem ? w_a_res : '1;
    end else if (w_ovf) begin
      w_spec_res = w_rem ? '0 : w_a_res;
    end
  end

  // --------------------------------------------------------------------------
  // One restoring step
  // --------------------------------------------------------------------------
  logic [XLEN:0]   w_rem_sh;     // N+1 bits: shifted remainder can exceed XLEN bits
  logic            w_ge;
  logic [XLEN-1:0] w_rem_nx;
  logic [XLEN-1:0] w_q_nx;

  assign w_rem_sh = {r_rem, r_q[XLEN-1]};
  assign w_ge     = (w_rem_sh >= {1'b0, r_dvs});
  // When w_ge holds the true difference is below the divisor, so the
  // low XLEN bits of the subtraction are exact.
  assign w_rem_nx = w_ge ? (w_rem_sh[XLEN-1:0] - r_dvs) : w_rem_sh[XLEN-1:0];
  assign w_q_nx   = {r_q[XLEN-2:0], w_ge};

  // --------------------------------------------------------------------------
  // Sign correction and result selection
  // --------------------------------------------------------------------------
  logic [XLEN-1:0] w_mag;
  logic            w_neg;
  logic [XLEN-1:0] w_sgn;
  logic [XLEN-1:0] w_fix;
  logic [XLEN-1:0] w_final;

  assign w_mag   = r_is_rem ? r_rem
                            : (r_word ? {{(XLEN-32){1'b0}}, r_q[31:0]} : r_q);
  assign w_neg   = r_is_rem ? r_neg_r : r_neg_q;
  assign w_sgn   = w_neg ? (~w_mag + 1'b1) : w_mag;
  assign w_fix   = r_word ? {{(XLEN-32){w_sgn[31]}}, w_sgn[31:0]} : w_sgn;
  assign w_final = r_special ? r_spec_res : w_fix;

  // --------------------------------------------------------------------------
  // Control FSM and datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_q        <= '0;
      r_rem      <= '0;
      r_dvs      <= '0;
      r_word     <= 1'b0;
      r_is_rem   <= 1'b0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_special  <= 1'b0;
      r_spec_res <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_result   <= '0;
    end else if (bus.kill_i) begin
      // Flush: abandon the operation, keep the last result visible.
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start_i) begin
            r_q        <= w_q_init;
            r_rem      <= '0;
            r_dvs      <= w_b_abs;
            r_word     <= bus.word_i;
            r_is_rem   <= w_rem;
            r_neg_q    <= w_sa ^ w_sb;
            r_neg_r    <= w_sa;
            r_special  <= w_dz | w_ovf;
            r_spec_res <= w_spec_res;
            r_cnt      <= bus.word_i ? 7'd32 : 7'd64;
`ifdef DIV_FASTPATH_EN
            if (w_dz | w_ovf) begin
              r_result <= w_spec_res;
              r_done   <= 1'b1;
            end else begin
              r_state <= S_CALC;
              r_busy  <= 1'b1;
            end
`else
            r_state <= S_CALC;
            r_busy  <= 1'b1;
`endif
          end
        end
        S_CALC: begin
          r_q   <= w_q_nx;
          r_rem <= w_rem_nx;
          r_cnt <= r_cnt - 7'd1;
          if (r_cnt == 7'd1) begin
            r_state <= S_FIX;
          end
        end
        S_FIX: begin
          r_result <= w_final;
          r_done   <= 1'b1;
          r_busy   <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_div_unit
//  Description : Self-checking bench for div_unit: directed cases, kill,
//                reset, back-to-back and randomized ops against an
//                arithmetic reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_div_unit;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  div_unit_if #(.XLEN(64)) bus ();

  div_unit #(.XLEN(64)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=0x%016h expected=0x%016h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // ---------------- reference model ----------------
  function automatic logic is_sgn(input logic [2:0] f3);
    return (f3 == 3'b100) || (f3 == 3'b110);
  endfunction

  function automatic logic is_rm(input logic [2:0] f3);
    return (f3 == 3'b110) || (f3 == 3'b111);
  endfunction

  function automatic logic is_special(input logic [2:0] f3, input logic w,
                                      input logic [63:0] a, input logic [63:0] b);
    if (w) return (b[31:0] == 32'd0) ||
                  (is_sgn(f3) && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF);
    return (b == 64'd0) ||
           (is_sgn(f3) && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF);
  endfunction

  function automatic logic [63:0] model(input logic [2:0] f3, input logic w,
                                       input logic [63:0] a, input logic [63:0] b);
    logic sg, rm;
    sg = is_sgn(f3);
    rm = is_rm(f3);
    if (w) begin
      logic [31:0] a32, b32, r32;
      logic signed [31:0] sa, sb;
      a32 = a[31:0]; b32 = b[31:0]; sa = a32; sb = b32;
      if (b32 == 0)                                           r32 = rm ? a32 : 32'hFFFF_FFFF;
      else if (sg && a32 == 32'h8000_0000 && b32 == '1)       r32 = rm ? 32'd0 : a32;
      else if (sg)                                            r32 = rm ? 32'(sa % sb) : 32'(sa / sb);
      else                                                    r32 = rm ? a32 % b32 : a32 / b32;
      return {{32{r32[31]}}, r32};
    end else begin
      logic signed [63:0] sa, sb;
      sa = a; sb = b;
      if (b == 0)                                             return rm ? a : '1;
      if (sg && a == 64'h8000_0000_0000_0000 && b == '1)      return rm ? 64'd0 : a;
      if (sg)                                                 return rm ? 64'(sa % sb) : 64'(sa / sb);
      return rm ? a % b : a / b;
    end
  endfunction

  function automatic int latency(input logic [2:0] f3, input logic w,
                                 input logic [63:0] a, input logic [63:0] b);
`ifdef DIV_FASTPATH_EN
    if (is_special(f3, w, a, b)) return 1;
`else
    if (is_special(f3, w, a, b)) return w ? 34 : 66;
`endif
    return w ? 34 : 66;
  endfunction

  // Issue one op in the current cycle (cycle 0), return in its done cycle
  // (or one cycle later when chk_after is set). spur_at>0 pulses a bogus
  // start in that cycle while the unit is busy.
  task automatic run_op(input string tag, input logic [2:0] f3, input logic w,
                        input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] exp, input int spur_at, input logic chk_after);
    int k, lat;
    logic seen;
    lat = latency(f3, w, a, b);
    bus.start_i = 1'b1; bus.funct3_i = f3; bus.word_i = w;
    bus.dividend_i = a; bus.divisor_i = b;
    step();
    bus.start_i = 1'b0;
    bus.dividend_i = ~a; bus.divisor_i = {$urandom(), $urandom()};
    k = 1; seen = 1'b0;
    while (k <= 200) begin
      bus.start_i = 1'b0;
      if (k == 1) chk({tag, ".busy1"}, 64'(bus.busy_o), (lat > 1) ? 64'd1 : 64'd0);
      if (bus.done_o) begin seen = 1'b1; break; end
      if (k == spur_at) begin
        bus.start_i = 1'b1; bus.funct3_i = 3'b101; bus.word_i = 1'b0;
        bus.dividend_i = 64'd12345; bus.divisor_i = 64'd3;
      end
      step();
      k++;
    end
    bus.start_i = 1'b0;
    chk({tag, ".lat"}, seen ? 64'(k) : 64'hDEAD, 64'(lat));
    chk({tag, ".res"}, bus.result_o, exp);
    chk({tag, ".busy_done"}, 64'(bus.busy_o), 64'd0);
    if (chk_after) begin
      step();
      chk({tag, ".pulse"}, 64'(bus.done_o), 64'd0);
      chk({tag, ".hold"}, bus.result_o, exp);
    end
  endtask

  initial begin
    logic [63:0] prev, a, b;
    logic [2:0]  f3;
    logic        w;
    int          extra, sel;

    bus.start_i = 1'b0; bus.kill_i = 1'b0; bus.funct3_i = 3'b000; bus.word_i = 1'b0;
    bus.dividend_i = '0; bus.divisor_i = '0;
    step(); step(); step();
    chk("rst.busy", 64'(bus.busy_o), 64'd0);
    chk("rst.done", 64'(bus.done_o), 64'd0);
    chk("rst.res",  bus.result_o, 64'd0);
    rst_ni = 1'b1;
    step();

    // Directed cases
    run_op("divu100_7",  3'b101, 1'b0, 64'd100, 64'd7, 64'd14, 0, 1'b1);
    run_op("remu100_7",  3'b111, 1'b0, 64'd100, 64'd7, 64'd2,  0, 1'b1);
    run_op("div-100_7",  3'b100, 1'b0, -64'sd100, 64'd7, 64'hFFFF_FFFF_FFFF_FFF2, 0, 1'b1);
    run_op("rem-100_7",  3'b110, 1'b0, -64'sd100, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 0, 1'b1);
    run_op("rem100_-7",  3'b110, 1'b0, 64'd100, -64'sd7, 64'd2, 0, 1'b1);
    run_op("divw_ovf",   3'b100, 1'b1, 64'h0000_0000_8000_0000, '1, 64'hFFFF_FFFF_8000_0000, 0, 1'b1);
    run_op("remw_ovf",   3'b110, 1'b1, 64'h0000_0000_8000_0000, '1, 64'd0, 0, 1'b1);
    run_op("div_by0",    3'b100, 1'b0, -64'sd5, 64'd0, '1, 0, 1'b1);
    run_op("remu_by0",   3'b111, 1'b0, 64'd9, 64'd0, 64'd9, 0, 1'b1);
    run_op("div_ovf64",  3'b100, 1'b0, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 0, 1'b1);
    run_op("remuw_by0",  3'b111, 1'b1, 64'h1234_5678_9ABC_DEF0, 64'hFFFF_FFFF_0000_0000,
           64'hFFFF_FFFF_9ABC_DEF0, 0, 1'b1);
    run_op("f3_011",     3'b011, 1'b0, 64'hFFFF_FFFF_FFFF_FFF0, 64'd16, 64'h0FFF_FFFF_FFFF_FFFF, 0, 1'b1);

    // Kill mid-operation, then a fresh start in the cycle after the kill
    prev = bus.result_o;
    bus.start_i = 1'b1; bus.funct3_i = 3'b101; bus.word_i = 1'b0;
    bus.dividend_i = 64'd1000; bus.divisor_i = 64'd10;
    step();
    bus.start_i = 1'b0;
    extra = 0;
    for (int k = 1; k < 20; k++) begin
      if (bus.done_o) extra++;
      step();
    end
    bus.kill_i = 1'b1;
    step();
    bus.kill_i = 1'b0;
    chk("kill.busy", 64'(bus.busy_o), 64'd0);
    chk("kill.done", 64'(bus.done_o | (extra != 0)), 64'd0);
    chk("kill.hold", bus.result_o, prev);
    run_op("after_kill", 3'b101, 1'b0, 64'd1000, 64'd10, 64'd100, 0, 1'b0);

    // Back-to-back: second start in the first op's done cycle; spurious
    // start while busy must be ignored
    run_op("b2b_1", 3'b101, 1'b0, 64'd100, 64'd7, 64'd14, 0, 1'b0);
    run_op("b2b_2", 3'b111, 1'b0, 64'd100, 64'd7, 64'd2, 10, 1'b1);
    extra = 0;
    for (int k = 0; k < 70; k++) begin
      if (bus.done_o) extra++;
      step();
    end
    chk("spur.no_done", 64'(extra), 64'd0);

    // Kill and start together: start is dropped (special op included)
    prev = bus.result_o;
    bus.start_i = 1'b1; bus.kill_i = 1'b1; bus.funct3_i = 3'b101; bus.word_i = 1'b0;
    bus.dividend_i = 64'd7; bus.divisor_i = 64'd0;
    step();
    bus.start_i = 1'b0; bus.kill_i = 1'b0;
    chk("killstart.busy", 64'(bus.busy_o), 64'd0);
    chk("killstart.done", 64'(bus.done_o), 64'd0);
    chk("killstart.hold", bus.result_o, prev);

    // Reset mid-operation clears result_o
    run_op("pre_rst", 3'b100, 1'b1, 64'd77, 64'd5, 64'd15, 0, 1'b0);
    bus.start_i = 1'b1; bus.funct3_i = 3'b101; bus.word_i = 1'b0;
    bus.dividend_i = 64'd999; bus.divisor_i = 64'd3;
    step();
    bus.start_i = 1'b0;
    for (int k = 0; k < 10; k++) step();
    rst_ni = 1'b0;
    step();
    rst_ni = 1'b1;
    chk("midrst.busy", 64'(bus.busy_o), 64'd0);
    chk("midrst.res",  bus.result_o, 64'd0);
    extra = 0;
    for (int k = 0; k < 70; k++) begin
      if (bus.done_o) extra++;
      step();
    end
    chk("midrst.no_done", 64'(extra), 64'd0);

    // Randomized ops against the reference model
    for (int i = 0; i < 24; i++) begin
      f3 = ($urandom_range(0, 3) != 0) ? 3'(4 + $urandom_range(0, 3)) : 3'($urandom_range(0, 3));
      w  = 1'($urandom_range(0, 1));
      sel = $urandom_range(0, 5);
      a = {$urandom(), $urandom()};
      b = {$urandom(), $urandom()};
      case (sel)
        1: begin a = 64'($urandom_range(0, 5000)); b = 64'($urandom_range(1, 60)); end
        2: b = w ? {$urandom(), 32'd0} : 64'd0;
        3: begin
             f3 = 3'b100 | 3'($urandom_range(0, 1) << 1);
             a  = w ? {$urandom(), 32'h8000_0000} : 64'h8000_0000_0000_0000;
             b  = w ? {$urandom(), 32'hFFFF_FFFF} : '1;
           end
        4: begin a = -64'($urandom_range(1, 100000)); b = 64'($urandom_range(1, 300)); end
        5: b = {32'd0, 16'd0, 16'($urandom())} | 64'd1;
        default: ;
      endcase
      run_op($sformatf("rnd%0d", i), f3, w, a, b, model(f3, w, a, b), 0, 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
